rgb_led_top: RTL and testbench

- Top-level LED demo block for a 12 MHz iCE40 board.
- Steps a fixed 8-entry colour palette at a programmable rate.
- Drives the on-board RGB LED through three 8-bit PWM channels.
- Outputs are active-low: 0 = LED lit.

---
 rtl/rgb_led_top.sv | 166 ++++++++++++++++
 tb/tb_rgb_led_top.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_led_top.sv
// rgb_led_top: steps an 8-colour palette and drives active-low RGB PWM.
// Optional triangle breathing brightness: define RGB_LED_BREATHE_EN.
module rgb_led_top #(
  parameter int PWM_BITS      = 8,
  parameter int STEP_TICKS    = 12000,
  parameter int BREATHE_TICKS = 47
) (
  input  logic CLK,
  input  logic RST,
  output logic LED_R,
  output logic LED_G,
  output logic LED_B
);

  localparam int SW = $clog2(STEP_TICKS);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_TICKS - 1);

  typedef logic [PWM_BITS-1:0] duty_t;

  // Declaration initialisers give X-free power-up without a reset pulse.
  duty_t         pwm_q  = '0;
  duty_t         pwm_d;
  logic [SW-1:0] step_q = '0;
  logic [SW-1:0] step_d;
  logic [2:0]    idx_q  = '0;
  logic [2:0]    idx_d;
  logic [2:0]    led_q  = '1;
  logic [2:0]    led_d;

  duty_t duty_r, duty_g, duty_b;
  duty_t eff_r, eff_g, eff_b;

  always_comb begin
    pwm_d  = pwm_q + 1'b1;
    step_d = step_q + 1'b1;
    idx_d  = idx_q;
    if (step_q == STEP_LAST) begin
      step_d = '0;
      idx_d  = idx_q + 3'd1;
    end
  end

  always_comb begin
    duty_r = '0;
    duty_g = '0;
    duty_b = '0;
    unique case (idx_q)
      3'd0: begin
        duty_r = duty_t'(8'd255);
      end
      3'd1: begin
        duty_r = duty_t'(8'd255);
        duty_g = duty_t'(8'd128);
      end
      3'd2: begin
        duty_g = duty_t'(8'd255);
      end
      3'd3: begin
        duty_g = duty_t'(8'd255);
        duty_b = duty_t'(8'd255);
      end
      3'd4: begin
        duty_b = duty_t'(8'd255);
      end
      3'd5: begin
        duty_r = duty_t'(8'd255);
        duty_b = duty_t'(8'd255);
      end
      3'd6: begin
        duty_r = duty_t'(8'd255);
        duty_g = duty_t'(8'd255);
        duty_b = duty_t'(8'd255);
      end
      3'd7: begin
        duty_r = duty_t'(8'd32);
        duty_g = duty_t'(8'd32);
        duty_b = duty_t'(8'd32);
      end
    endcase
  end

`ifdef RGB_LED_BREATHE_EN
  localparam int BW = (BREATHE_TICKS > 1) ? $clog2(BREATHE_TICKS) : 1;
  localparam logic [BW-1:0] BR_LAST = BW'(BREATHE_TICKS - 1);
  localparam duty_t BRI_MAX = '1;

  logic [BW-1:0] brc_q = '0;
  logic [BW-1:0] brc_d;
  duty_t         bri_q = '0;
  duty_t         bri_d;
  logic          up_q  = 1'b1;
  logic          up_d;

  // Endpoints are held one step: the turn-around step moves away from them.
  always_comb begin
    brc_d = brc_q + 1'b1;
    bri_d = bri_q;
    up_d  = up_q;
    if (brc_q == BR_LAST) begin
      brc_d = '0;
      if (up_q) begin
        if (bri_q == BRI_MAX) begin
          up_d  = 1'b0;
          bri_d = bri_q - 1'b1;
        end else begin
          bri_d = bri_q + 1'b1;
        end
      end else begin
        if (bri_q == '0) begin
          up_d  = 1'b1;
          bri_d = bri_q + 1'b1;
        end else begin
          bri_d = bri_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      brc_q <= '0;
      bri_q <= '0;
      up_q  <= 1'b1;
    end else begin
      brc_q <= brc_d;
      bri_q <= bri_d;
      up_q  <= up_d;
    end
  end

  function automatic duty_t scale(input duty_t d, input duty_t b);
    logic [2*PWM_BITS-1:0] p;
    p = {{PWM_BITS{1'b0}}, d} * ({{PWM_BITS{1'b0}}, b} + 1'b1);
    return p[2*PWM_BITS-1:PWM_BITS];
  endfunction

  assign eff_r = scale(duty_r, bri_q);
  assign eff_g = scale(duty_g, bri_q);
  assign eff_b = scale(duty_b, bri_q);
`else
  assign eff_r = duty_r;
  assign eff_g = duty_g;
  assign eff_b = duty_b;
`endif

  always_comb begin
    led_d = {~(pwm_q < eff_r), ~(pwm_q < eff_g), ~(pwm_q < eff_b)};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pwm_q  <= '0;
      step_q <= '0;
      idx_q  <= '0;
      led_q  <= '1;
    end else begin
      pwm_q  <= pwm_d;
      step_q <= step_d;
      idx_q  <= idx_d;
      led_q  <= led_d;
    end
  end

  assign {LED_R, LED_G, LED_B} = led_q;

endmodule

// File: tb/tb_rgb_led_top.sv
// tb_rgb_led_top: random-reset bench against an arithmetic LED model.
// Also builds with RGB_LED_BREATHE_EN to check breathing brightness.
module tb_rgb_led_top;

  localparam int ST = 1000;
  localparam int BT = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic led_r, led_g, led_b;

  int total = 0;
  int bad   = 0;
  int t     = 0;

  int pal_r[8] = '{255, 255, 0,   0,   0,   255, 255, 32};
  int pal_g[8] = '{0,   128, 255, 255, 0,   0,   255, 32};
  int pal_b[8] = '{0,   0,   0,   255, 255, 255, 255, 32};

  rgb_led_top #(
    .PWM_BITS(8),
    .STEP_TICKS(ST),
    .BREATHE_TICKS(BT)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .LED_R(led_r),
    .LED_G(led_g),
    .LED_B(led_b)
  );

  always #5 clk = ~clk;

  // LED levels produced by the edge that consumes state at tt cycles
  // after reset release.
  function automatic logic [2:0] model(input int tt);
    int pwm, idx, dr, dg, db;
    pwm = tt % 256;
    idx = (tt / ST) % 8;
    dr  = pal_r[idx];
    dg  = pal_g[idx];
    db  = pal_b[idx];
`ifdef RGB_LED_BREATHE_EN
    begin
      int s, p, bri;
      s   = tt / BT;
      p   = s % 510;
      bri = (p <= 255) ? p : 510 - p;
      dr  = (dr * (bri + 1)) / 256;
      dg  = (dg * (bri + 1)) / 256;
      db  = (db * (bri + 1)) / 256;
    end
`endif
    return {pwm >= dr, pwm >= dg, pwm >= db};
  endfunction

  task automatic tick(output logic [2:0] e, output int tt);
    @(posedge clk);
    #1;
    tt = t;
    if (rst) begin
      e  = 3'b111;
      t  = 0;
      tt = -1;
    end else begin
      e = model(t);
      t++;
    end
  endtask

  task automatic test_powerup();
    logic [2:0] e;
    int tt;
    rst = 1'b0;
    t   = 0;
    for (int k = 0; k < 20; k++) begin
      tick(e, tt);
      total++;
      if ({led_r, led_g, led_b} !== e) begin
        bad++;
        $display("FAIL powerup t=%0d got=%b exp=%b", tt,
                 {led_r, led_g, led_b}, e);
      end
    end
  endtask

  task automatic test_reset();
    logic [2:0] e;
    int tt, nr, ng, nb;
    rst = 1'b1;
    repeat (3) begin
      tick(e, tt);
      total++;
      if ({led_r, led_g, led_b} !== 3'b111) begin
        bad++;
        $display("FAIL reset_hold got=%b exp=111", {led_r, led_g, led_b});
      end
    end
    rst = 1'b0;
    nr = 0;
    ng = 0;
    nb = 0;
    for (int k = 0; k < 512; k++) begin
      tick(e, tt);
      total++;
      if ({led_r, led_g, led_b} !== e) begin
        bad++;
        $display("FAIL reset_run t=%0d got=%b exp=%b", tt,
                 {led_r, led_g, led_b}, e);
      end
      if (k >= 1 && k <= 256) begin
        if (!led_r) nr++;
        if (!led_g) ng++;
        if (!led_b) nb++;
      end
    end
`ifndef RGB_LED_BREATHE_EN
    total++;
    if (nr != 255) begin
      bad++;
      $display("FAIL reset_duty_r got=%0d exp=255", nr);
    end
    total++;
    if (ng != 0 || nb != 0) begin
      bad++;
      $display("FAIL reset_duty_gb got=%0d/%0d exp=0/0", ng, nb);
    end
`endif
  endtask

  task automatic test_step();
    logic [2:0] e;
    int tt, nr, ng;
    nr = 0;
    ng = 0;
    for (int k = 0; k < 2 * ST && t < ST + 300; k++) begin
      tick(e, tt);
      total++;
      if ({led_r, led_g, led_b} !== e) begin
        bad++;
        $display("FAIL step t=%0d got=%b exp=%b", tt,
                 {led_r, led_g, led_b}, e);
      end
      if (tt >= ST && tt < ST + 256) begin
        if (!led_r) nr++;
        if (!led_g) ng++;
      end
    end
`ifndef RGB_LED_BREATHE_EN
    total++;
    if (nr != 255 || ng != 128) begin
      bad++;
      $display("FAIL step_duty got=%0d/%0d exp=255/128", nr, ng);
    end
`endif
  endtask

  task automatic test_wrap();
    logic [2:0] e;
    int tt, n7r, n7g, n7b, n0r, n0g;
    n7r = 0;
    n7g = 0;
    n7b = 0;
    n0r = 0;
    n0g = 0;
    for (int k = 0; k < 9 * ST && t < 8 * ST + 300; k++) begin
      tick(e, tt);
      total++;
      if ({led_r, led_g, led_b} !== e) begin
        bad++;
        $display("FAIL wrap t=%0d got=%b exp=%b", tt,
                 {led_r, led_g, led_b}, e);
      end
      if (tt >= 7 * ST && tt < 7 * ST + 256) begin
        if (!led_r) n7r++;
        if (!led_g) n7g++;
        if (!led_b) n7b++;
      end
      if (tt >= 8 * ST && tt < 8 * ST + 256) begin
        if (!led_r) n0r++;
        if (!led_g) n0g++;
      end
    end
`ifndef RGB_LED_BREATHE_EN
    total++;
    if (n7r != 32 || n7g != 32 || n7b != 32) begin
      bad++;
      $display("FAIL wrap_idx7 got=%0d/%0d/%0d exp=32/32/32",
               n7r, n7g, n7b);
    end
    total++;
    if (n0r != 255 || n0g != 0) begin
      bad++;
      $display("FAIL wrap_idx0 got=%0d/%0d exp=255/0", n0r, n0g);
    end
`endif
  endtask

  task automatic test_duty0();
    logic [2:0] e;
    int tt, nr, ng, nb;
    rst = 1'b1;
    tick(e, tt);
    rst = 1'b0;
    nr = 0;
    ng = 0;
    nb = 0;
    for (int k = 0; k < 6 * ST && t < 5 * ST; k++) begin
      tick(e, tt);
      total++;
      if ({led_r, led_g, led_b} !== e) begin
        bad++;
        $display("FAIL duty0_run t=%0d got=%b exp=%b", tt,
                 {led_r, led_g, led_b}, e);
      end
      if (tt >= 4 * ST) begin
        if (!led_r) nr++;
        if (!led_g) ng++;
        if (!led_b) nb++;
      end
    end
    total++;
    if (nr != 0 || ng != 0) begin
      bad++;
      $display("FAIL duty0 got=%0d/%0d exp=0/0", nr, ng);
    end
    total++;
    if (nb == 0) begin
      bad++;
      $display("FAIL duty0_blue got=%0d exp=>0", nb);
    end
  endtask

  task automatic test_mid_reset();
    logic [2:0] e;
    int tt, tgt;
    rst = 1'b1;
    tick(e, tt);
    rst = 1'b0;
    tgt = 2 * ST + int'($urandom_range(10, ST - 10));
    for (int k = 0; k < 4 * ST && t < tgt; k++) begin
      tick(e, tt);
      total++;
      if ({led_r, led_g, led_b} !== e) begin
        bad++;
        $display("FAIL midrst_pre t=%0d got=%b exp=%b", tt,
                 {led_r, led_g, led_b}, e);
      end
    end
    rst = 1'b1;
    tick(e, tt);
    total++;
    if ({led_r, led_g, led_b} !== 3'b111) begin
      bad++;
      $display("FAIL midrst_hold got=%b exp=111", {led_r, led_g, led_b});
    end
    rst = 1'b0;
    for (int k = 0; k < ST + 300; k++) begin
      tick(e, tt);
      total++;
      if ({led_r, led_g, led_b} !== e) begin
        bad++;
        $display("FAIL midrst_post t=%0d got=%b exp=%b", tt,
                 {led_r, led_g, led_b}, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] e;
    int tt, nrst, nrun;
    for (int i = 0; i < 6; i++) begin
      nrst = int'($urandom_range(1, 4));
      nrun = int'($urandom_range(1, 700));
      rst  = 1'b1;
      for (int k = 0; k < nrst; k++) begin
        tick(e, tt);
        total++;
        if ({led_r, led_g, led_b} !== 3'b111) begin
          bad++;
          $display("FAIL b2b_hold i=%0d got=%b exp=111", i,
                   {led_r, led_g, led_b});
        end
      end
      rst = 1'b0;
      for (int k = 0; k < nrun; k++) begin
        tick(e, tt);
        total++;
        if ({led_r, led_g, led_b} !== e) begin
          bad++;
          $display("FAIL b2b_run i=%0d t=%0d got=%b exp=%b", i, tt,
                   {led_r, led_g, led_b}, e);
        end
      end
    end
  endtask

`ifdef RGB_LED_BREATHE_EN
  task automatic test_breathe();
    logic [2:0] e;
    int tt, n0;
    rst = 1'b1;
    tick(e, tt);
    rst = 1'b0;
    n0 = 0;
    for (int k = 0; k < 510 * BT + 300; k++) begin
      tick(e, tt);
      total++;
      if ({led_r, led_g, led_b} !== e) begin
        bad++;
        $display("FAIL breathe t=%0d got=%b exp=%b", tt,
                 {led_r, led_g, led_b}, e);
      end
      if (tt < BT && !led_r) n0++;
    end
    total++;
    if (n0 != 0) begin
      bad++;
      $display("FAIL breathe_bri0 got=%0d exp=0", n0);
    end
  endtask
`endif

  initial begin
    #5000000;
    $display("FAIL watchdog t=%0d got=timeout exp=finish", t);
    $fatal(1);
  end

  initial begin
    test_powerup();
    test_reset();
    test_step();
    test_wrap();
    test_duty0();
    test_mid_reset();
    test_back_to_back();
`ifdef RGB_LED_BREATHE_EN
    test_breathe();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
